// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts decoded ALU instructions, drives the ALU control
// fields and sequences RAM, stack and mul/div waits before the write strobe.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to bound every wait state by
// TIMEOUT_CYC cycles. When it is left undefined, waits are unbounded and
// timeout_err is tied low.
module alu_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_ra,
    input  logic [1:0]  i_rb,
    input  logic [15:0] i_imm,
    output logic [3:0]  mOper,
    output logic [1:0]  reg1,
    output logic [1:0]  reg2,
    output logic [15:0] data,
    output logic        s,
    output logic        ram_req,
    input  logic        ram_ack,
    output logic        md_start,
    input  logic        md_done,
    output logic        stk_req,
    input  logic        stk_ack,
    input  logic        overflow,
    output logic        ovf_flag,
    input  logic        ovf_clr,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [3:0] OP_POP  = 4'd0;
    localparam logic [3:0] OP_RES  = 4'd5;
    localparam logic [3:0] OP_READ = 4'd6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RAM,
        WAIT_MD,
        WAIT_STK
    } state_t;

    state_t state;
    logic   take;
    logic   done_hit;
    logic   expire;
    logic   in_wait;

    assign take    = i_valid & i_ready;
    assign in_wait = (state == WAIT_RAM) | (state == WAIT_MD) | (state == WAIT_STK);

    // Completion qualifier: only the ack/done matching the current wait counts;
    // md_done is ignored during the md_start cycle.
    always_comb begin
        done_hit = 1'b0;
        case (state)
            WAIT_RAM: done_hit = ram_ack;
            WAIT_STK: done_hit = stk_ack;
            WAIT_MD:  done_hit = md_done & ~md_start;
            default:  done_hit = 1'b0;
        endcase
    end

    // Write strobe is high in the same cycle the completion is observed.
    assign s = (state == ISSUE) | done_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign expire = (wait_cnt == 8'(TIMEOUT_CYC - 1));

    // Wait-cycle counter and sticky timeout flag; a completion on the last
    // allowed cycle takes priority over the abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (!in_wait) begin
                wait_cnt <= 8'd0;
            end else if (!done_hit && !expire) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            timeout_err <= (in_wait & ~done_hit & expire) | (timeout_err & ~ovf_clr);
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^8'(TIMEOUT_CYC);
    assign timeout_err    = 1'b0;
`endif

    // Sequencer state machine with registered handshake and control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            i_ready  <= 1'b1;
            busy     <= 1'b0;
            ram_req  <= 1'b0;
            stk_req  <= 1'b0;
            md_start <= 1'b0;
            mOper    <= 4'd0;
            reg1     <= 2'd0;
            reg2     <= 2'd0;
            data     <= 16'd0;
            ovf_flag <= 1'b0;
        end else begin
            ovf_flag <= (s & overflow) | (ovf_flag & ~ovf_clr);
            md_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        mOper   <= i_op;
                        reg1    <= i_ra;
                        reg2    <= i_rb;
                        data    <= i_imm;
                        busy    <= 1'b1;
                        i_ready <= 1'b0;
                        case (i_op)
                            OP_READ: begin
                                state   <= WAIT_RAM;
                                ram_req <= 1'b1;
                            end
                            OP_RES: begin
                                state    <= WAIT_MD;
                                md_start <= 1'b1;
                            end
                            OP_POP: begin
                                state   <= WAIT_STK;
                                stk_req <= 1'b1;
                            end
                            default: state <= ISSUE;
                        endcase
                    end
                end
                ISSUE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    i_ready <= 1'b1;
                end
                WAIT_RAM, WAIT_MD, WAIT_STK: begin
                    if (done_hit || expire) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        i_ready <= 1'b1;
                        ram_req <= 1'b0;
                        stk_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    i_ready <= 1'b1;
                    ram_req <= 1'b0;
                    stk_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level schedule model.
module tb_alu_sequencer;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [3:0]  i_op;
    logic [1:0]  i_ra, i_rb;
    logic [15:0] i_imm;
    logic [3:0]  mOper;
    logic [1:0]  reg1, reg2;
    logic [15:0] data;
    logic        s, ram_req, ram_ack, md_start, md_done, stk_req, stk_ack;
    logic        overflow, ovf_flag, ovf_clr, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic ovf_m = 1'b0;
    logic tmo_m = 1'b0;

    alu_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_op(i_op), .i_ra(i_ra), .i_rb(i_rb), .i_imm(i_imm),
        .mOper(mOper), .reg1(reg1), .reg2(reg2), .data(data), .s(s),
        .ram_req(ram_req), .ram_ack(ram_ack), .md_start(md_start), .md_done(md_done),
        .stk_req(stk_req), .stk_ack(stk_ack), .overflow(overflow),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic drive_zero();
        i_valid = 1'b0; i_op = 4'd0; i_ra = 2'd0; i_rb = 2'd0; i_imm = 16'd0;
        ram_ack = 1'b0; stk_ack = 1'b0; md_done = 1'b0; overflow = 1'b0; ovf_clr = 1'b0;
    endtask

    // One full transaction: accept, busy window, return to IDLE.
    // delay = cycles before the completing ack (RAM/STK) or before the first
    // eligible cycle for md_done (MD); early adds an md_done on the start cycle.
    task automatic run_txn(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                           input logic [15:0] imm, input int delay, input bit early);
        int len;
        bit is_ram, is_stk, is_md, es;
        logic [7:0] exp_c, got_c;
        logic [23:0] exp_r, got_r;
        is_ram = (op == 4'd6);
        is_stk = (op == 4'd0);
        is_md  = (op == 4'd5);
        len = is_md ? delay + 2 : ((is_ram || is_stk) ? delay + 1 : 1);
        exp_r = {op, ra, rb, imm};

        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_ra = ra; i_rb = rb; i_imm = imm;
        ram_ack = 1'($urandom); stk_ack = 1'($urandom); md_done = 1'($urandom);
        overflow = 1'($urandom); ovf_clr = 1'($urandom);
        #1;
        n_checks++;
        if ({i_ready, busy, s} !== 3'b100) begin
            n_fail++;
            $display("FAIL accept op=%0d: ready/busy/s got %b want 100", op, {i_ready, busy, s});
        end
        @(posedge clk);
        ovf_m = ovf_m & ~ovf_clr;
        tmo_m = tmo_m & ~ovf_clr;

        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            i_valid = 1'($urandom); i_op = 4'($urandom); i_ra = 2'($urandom);
            i_rb = 2'($urandom); i_imm = 16'($urandom);
            overflow = 1'($urandom); ovf_clr = 1'($urandom);
            ram_ack = is_ram ? (c == len) : 1'($urandom);
            stk_ack = is_stk ? (c == len) : 1'($urandom);
            md_done = is_md ? ((c == len) || (c == 1 && early)) : 1'($urandom);
            es = (c == len);
            #1;
            exp_c = {es, 1'b1, 1'b0, is_ram, is_stk, is_md && (c == 1), ovf_m, tmo_m};
            got_c = {s, busy, i_ready, ram_req, stk_req, md_start, ovf_flag, timeout_err};
            n_checks++;
            if (got_c !== exp_c) begin
                n_fail++;
                $display("FAIL busy_ctl op=%0d cyc=%0d: s,busy,rdy,ram,stk,mds,ovf,tmo got %b want %b",
                         op, c, got_c, exp_c);
            end
            got_r = {mOper, reg1, reg2, data};
            n_checks++;
            if (got_r !== exp_r) begin
                n_fail++;
                $display("FAIL latched_fields op=%0d cyc=%0d: got %h want %h", op, c, got_r, exp_r);
            end
            @(posedge clk);
            ovf_m = (es & overflow) | (ovf_m & ~ovf_clr);
            tmo_m = tmo_m & ~ovf_clr;
        end

        @(negedge clk);
        i_valid = 1'b0;
        ram_ack = 1'($urandom); stk_ack = 1'($urandom); md_done = 1'($urandom);
        overflow = 1'($urandom); ovf_clr = 1'($urandom);
        #1;
        exp_c = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ovf_m, tmo_m};
        got_c = {s, busy, i_ready, ram_req, stk_req, md_start, ovf_flag, timeout_err};
        n_checks++;
        if (got_c !== exp_c || {mOper, reg1, reg2, data} !== exp_r) begin
            n_fail++;
            $display("FAIL back_to_idle op=%0d: ctl got %b want %b, fields got %h want %h",
                     op, got_c, exp_c, {mOper, reg1, reg2, data}, exp_r);
        end
        @(posedge clk);
        ovf_m = ovf_m & ~ovf_clr;
        tmo_m = tmo_m & ~ovf_clr;
    endtask

    task automatic test_reset();
        drive_zero();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s, ram_req, stk_req, md_start, busy, ovf_flag, timeout_err} !== 7'd0 ||
            {mOper, reg1, reg2, data} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_values: ctl got %b fields got %h want all zero",
                     {s, ram_req, stk_req, md_start, busy, ovf_flag, timeout_err},
                     {mOper, reg1, reg2, data});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({i_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: ready/busy got %b want 10", {i_ready, busy});
        end
        ovf_m = 1'b0;
        tmo_m = 1'b0;
    endtask

    task automatic test_issue();
        run_txn(4'd1, 2'd2, 2'd3, 16'h1234, 0, 1'b0);
        run_txn(4'd15, 2'd0, 2'd1, 16'hFFFF, 0, 1'b0);
    endtask

    task automatic test_ram_wait();
        run_txn(4'd6, 2'd1, 2'd0, 16'hA5A5, 4, 1'b0);
        run_txn(4'd6, 2'd3, 2'd3, 16'h0001, 7, 1'b0);
        run_txn(4'd0, 2'd2, 2'd1, 16'h8000, 7, 1'b0);
    endtask

    task automatic test_md_early_done();
        run_txn(4'd5, 2'd1, 2'd2, 16'h00C3, 2, 1'b1);
        run_txn(4'd5, 2'd0, 2'd3, 16'h7E7E, 6, 1'b0);
    endtask

    task automatic test_ovf_set_clear();
        @(negedge clk);
        drive_zero();
        i_valid = 1'b1; i_op = 4'd2; ovf_clr = 1'b1;
        @(posedge clk);
        ovf_m = 1'b0; tmo_m = 1'b0;
        @(negedge clk);
        i_valid = 1'b0; overflow = 1'b1; ovf_clr = 1'b1;
        #1;
        n_checks++;
        if (s !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_issue_strobe: s got %b want 1", s);
        end
        @(posedge clk);
        @(negedge clk);
        overflow = 1'b0; ovf_clr = 1'b1;
        #1;
        n_checks++;
        if (ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf_flag got %b want 1", ovf_flag);
        end
        @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        n_checks++;
        if (ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf_flag got %b want 0", ovf_flag);
        end
        ovf_m = 1'b0;
    endtask

    task automatic test_reset_mid_stk();
        @(negedge clk);
        drive_zero();
        i_valid = 1'b1; i_op = 4'd0; i_ra = 2'd1; i_rb = 2'd2; i_imm = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        n_checks++;
        if ({stk_req, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL stk_wait_entry: stk_req/busy got %b want 11", {stk_req, busy});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        stk_ack = 1'b1;
        #1;
        n_checks++;
        if ({s, stk_req, busy, ovf_flag} !== 4'd0 || {mOper, reg1, reg2, data} !== 24'd0) begin
            n_fail++;
            $display("FAIL async_abort: s/stk/busy/ovf got %b fields %h want zero",
                     {s, stk_req, busy, ovf_flag}, {mOper, reg1, reg2, data});
        end
        ovf_m = 1'b0; tmo_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({i_ready, busy, s, stk_req} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stale_ack_ignored: rdy/busy/s/stk got %b want 1000",
                     {i_ready, busy, s, stk_req});
        end
        stk_ack = 1'b0;
    endtask

    task automatic test_wait_limit();
        @(negedge clk);
        drive_zero();
        i_valid = 1'b1; i_op = 4'd6; ovf_clr = 1'b1;
        @(posedge clk);
        ovf_m = 1'b0; tmo_m = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        for (int c = 1; c <= int'(TO); c++) begin
            @(negedge clk);
            drive_zero();
            stk_ack = 1'($urandom); md_done = 1'($urandom);
            #1;
            n_checks++;
            if ({s, ram_req, busy, timeout_err} !== 4'b0110) begin
                n_fail++;
                $display("FAIL timeout_wait cyc=%0d: s/ram/busy/tmo got %b want 0110",
                         c, {s, ram_req, busy, timeout_err});
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive_zero();
        #1;
        n_checks++;
        if ({s, ram_req, busy, i_ready, timeout_err} !== 5'b00011) begin
            n_fail++;
            $display("FAIL timeout_abort: s/ram/busy/rdy/tmo got %b want 00011",
                     {s, ram_req, busy, i_ready, timeout_err});
        end
        ovf_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: timeout_err got %b want 0", timeout_err);
        end
`else
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            drive_zero();
            stk_ack = 1'($urandom); md_done = 1'($urandom);
            #1;
            n_checks++;
            if ({s, ram_req, busy, timeout_err} !== 4'b0110) begin
                n_fail++;
                $display("FAIL unbounded_wait cyc=%0d: s/ram/busy/tmo got %b want 0110",
                         c, {s, ram_req, busy, timeout_err});
            end
            @(posedge clk);
        end
        @(negedge clk);
        ram_ack = 1'b1;
        #1;
        n_checks++;
        if (s !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack_strobe: s got %b want 1", s);
        end
        @(posedge clk);
        @(negedge clk);
        drive_zero();
        #1;
        n_checks++;
        if ({i_ready, ram_req, s} !== 3'b100) begin
            n_fail++;
            $display("FAIL late_ack_idle: rdy/ram/s got %b want 100", {i_ready, ram_req, s});
        end
`endif
        @(posedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_txn(4'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
                    int'($urandom_range(0, 6)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_ram_wait();
        test_md_early_done();
        test_ovf_set_clear();
        test_reset_mid_stk();
        test_wait_limit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
